snn_weight_mem: RTL and testbench
=================================

Name: snn_weight_mem

Overview:
- Parametrised synaptic weight store for the reward-modulated SNN.
- Holds one unsigned weight per synapse address and supports plain read and write.
- Adds a reward-driven read-modify-write update that applies a signed delta with saturation.
- Adds a sequenced clear-all operation.
- Sits between the host/IO decode logic and the neuron/learning datapath; all accesses go through a single valid/ready request port and a one-cycle response pulse.

Parameters:
- DATA_W, 8, weight width in bits (unsigned, range 0..2^DATA_W-1).
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W entries.
- DELTA_W, 5, width of the signed two's-complement reward delta.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  2  00 READ, 01 WRITE, 10 UPDATE (reward add), 11 CLEAR (all entries).
- req_addr  input  ADDR_W  target entry; ignored for CLEAR.
- req_wdata  input  DATA_W  write data for WRITE.
- req_delta  input  DELTA_W  signed delta for UPDATE.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  DATA_W  response data.
- rsp_sat  output  1  UPDATE result was clamped; valid with rsp_valid.
- busy  output  1  multi-cycle operation in progress (equals !req_ready).

Behaviour:
- Reset (async, rst_n=0):
  - All DEPTH entries = 0.
  - State = IDLE.
  - rsp_valid=0, rsp_data=0, rsp_sat=0, busy=0, req_ready=1 once released.
  - Reset mid-UPDATE or mid-CLEAR aborts the operation; no response is issued.
- Handshake: request accepted at a rising edge where req_valid && req_ready. Inputs are sampled only at acceptance. No response backpressure; rsp_valid is a single-cycle pulse.
- States: IDLE, UPD, CLR.
- req_ready = (state==IDLE).
- READ, accepted at edge T:
  - rsp_data = mem[addr] during cycle T+1, rsp_valid=1, rsp_sat=0.
  - Stays in IDLE, so back-to-back requests are allowed every cycle.
- WRITE, accepted at edge T:
  - mem[addr] = req_wdata at edge T.
  - rsp_valid=1 with rsp_data=req_wdata in cycle T+1.
  - A READ of the same address accepted at T+1 returns the new value.
- UPDATE, accepted at edge T:
  - Capture addr, delta, and mem[addr] into internal registers; go to UPD.
  - At edge T+1: sum = weight + sign-extended delta, computed at DATA_W+2 bits.
  - If sum<0, result=0 and sat=1. If sum>2^DATA_W-1, result=2^DATA_W-1 and sat=1. Otherwise result=sum and sat=0.
  - Write result to mem[addr]; return to IDLE.
  - rsp_valid=1, rsp_data=result, rsp_sat=sat in cycle T+2.
  - req_ready=0 during cycle T+1 only.
- CLEAR, accepted at edge T:
  - Go to CLR with counter=0.
  - At each edge in CLR: mem[counter]=0 and counter increments.
  - After writing entry DEPTH-1, return to IDLE.
  - DEPTH cycles busy in total; rsp_valid=1 with rsp_data=0 in the cycle after the last write.
- Outside response cycles: rsp_valid=0; rsp_data holds its last value; rsp_sat=0.
- req_valid while busy: ignored, not queued; the requester must hold it until req_ready.
- Address wrap: the CLEAR counter is ADDR_W+1 bits, so there is no aliasing at DEPTH-1.
- Delta = 0: UPDATE rewrites the same value, sat=0.

Test Plan (DATA_W=8, ADDR_W=4, DELTA_W=5):
1. Assert reset, release, then READ all 16 addresses back-to-back -> every rsp_data=0x00, one rsp_valid per request, req_ready stays 1.
2. WRITE addr 3 = 0xA5, then READ addr 3 in the next cycle -> WRITE response 0xA5, READ response 0xA5; addr 4 still reads 0x00.
3. WRITE addr 7 = 0xFC, then UPDATE addr 7 delta=+7 -> rsp_data=0xFF, rsp_sat=1, req_ready low exactly one cycle. Then UPDATE delta=-16 -> rsp_data=0xEF, rsp_sat=0.
4. WRITE addr 0 = 0x03, then UPDATE addr 0 delta=-16 -> rsp_data=0x00, rsp_sat=1; subsequent READ returns 0x00.
5. Fill all 16 entries with 0x11 via WRITE, then CLEAR while holding a READ on req_valid during busy -> busy for 16 cycles, one response with 0x00; the held READ is accepted afterwards and returns 0x00; no response during CLR.
6. Assert rst_n low during the UPD cycle and during cycle 8 of CLR -> no rsp_valid is emitted; after release all entries read 0x00 and req_ready=1.

Source files
------------

// File: rtl/snn_weight_mem_if.sv
// Request/response bundle for the synaptic weight store: a valid/ready request
// channel and a single-cycle response pulse with no backpressure.
interface snn_weight_mem_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DELTA_W = 5
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [DELTA_W-1:0] req_delta;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_sat;
  logic               busy;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_delta,
    input  req_ready, rsp_valid, rsp_data, rsp_sat, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_delta,
    output req_ready, rsp_valid, rsp_data, rsp_sat, busy
  );
endinterface

// File: rtl/snn_weight_mem.sv
// Synaptic weight store: single-cycle read/write, two-cycle saturating reward
// update and a DEPTH-cycle sequenced clear of every entry.
module snn_weight_mem #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DELTA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  snn_weight_mem_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int SUM_W = DATA_W + 2;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_UPD   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_CLR} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0]  upd_addr_q;
  logic [DATA_W-1:0]  upd_w_q;
  logic [DELTA_W-1:0] upd_delta_q;
  logic [CNT_W-1:0]   clr_cnt_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_sat_q;

  logic [SUM_W-1:0]   upd_sum_d;
  logic               upd_neg_d;
  logic               upd_ovf_d;
  logic [DATA_W-1:0]  upd_res_d;

  // Sum is wide enough that the top bit is a reliable sign and bit DATA_W an overflow flag.
  always_comb begin
    upd_sum_d = {2'b00, upd_w_q}
              + {{(SUM_W-DELTA_W){upd_delta_q[DELTA_W-1]}}, upd_delta_q};
    upd_neg_d = upd_sum_d[SUM_W-1];
    upd_ovf_d = !upd_neg_d && upd_sum_d[DATA_W];
    upd_res_d = upd_sum_d[DATA_W-1:0];
    if (upd_neg_d)      upd_res_d = '0;
    else if (upd_ovf_d) upd_res_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      upd_addr_q  <= '0;
      upd_w_q     <= '0;
      upd_delta_q <= '0;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sat_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_sat_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            case (bus.req_op)
              OP_READ: begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= mem_q[bus.req_addr];
              end
              OP_WRITE: begin
                mem_q[bus.req_addr] <= bus.req_wdata;
                rsp_valid_q         <= 1'b1;
                rsp_data_q          <= bus.req_wdata;
              end
              OP_UPD: begin
                upd_addr_q  <= bus.req_addr;
                upd_w_q     <= mem_q[bus.req_addr];
                upd_delta_q <= bus.req_delta;
                state_q     <= S_UPD;
              end
              OP_CLR: begin
                clr_cnt_q <= '0;
                state_q   <= S_CLR;
              end
              default: ;
            endcase
          end
        end
        S_UPD: begin
          mem_q[upd_addr_q] <= upd_res_d;
          rsp_valid_q       <= 1'b1;
          rsp_data_q        <= upd_res_d;
          rsp_sat_q         <= upd_neg_d | upd_ovf_d;
          state_q           <= S_IDLE;
        end
        S_CLR: begin
          mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
          clr_cnt_q                    <= clr_cnt_q + CNT_W'(1);
          if (clr_cnt_q == CNT_W'(DEPTH-1)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_sat   = rsp_sat_q;
endmodule

// File: tb/tb_snn_weight_mem.sv
// Directed bench for snn_weight_mem: inputs change and outputs are sampled on
// the falling edge, so each check sees the cycle after the preceding rising edge.
module tb_snn_weight_mem;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   busy_cnt;
  int   rsp_seen;

  snn_weight_mem_if #(.DATA_W(8), .ADDR_W(4), .DELTA_W(5)) bus ();

  snn_weight_mem #(.DATA_W(8), .ADDR_W(4), .DELTA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] addr,
                       input logic [7:0] wdata, input logic [4:0] delta);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_delta = delta;
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_delta = '0;
  endtask

  // One single-cycle request (READ/WRITE); returns at the response cycle.
  task automatic single(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp, input string tag);
    drive(op, addr, wdata, 5'd0);
    @(negedge clk);
    idle_bus();
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.rsp_data),  32'(exp));
    chk({tag, "_sat"},   32'(bus.rsp_sat),   32'd0);
  endtask

  // UPDATE: checks the one-cycle ready drop and the response one cycle later.
  task automatic update(input logic [3:0] addr, input logic [4:0] delta,
                        input logic [7:0] exp, input logic exp_sat, input string tag);
    drive(2'b10, addr, 8'h00, delta);
    @(negedge clk);
    idle_bus();
    chk({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_no_rsp"},    32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.rsp_data),  32'(exp));
    chk({tag, "_sat"},   32'(bus.rsp_sat),   32'(exp_sat));
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_sat",   32'(bus.rsp_sat),   32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // 1: back-to-back reads of a freshly reset array
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 4'(i), 8'h00, 5'd0);
      @(negedge clk);
      chk($sformatf("rd0_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("rd0_data_%0d", i),  32'(bus.rsp_data),  32'd0);
      chk($sformatf("rd0_ready_%0d", i), 32'(bus.req_ready), 32'd1);
    end
    idle_bus();
    @(negedge clk);
    chk("rd0_pulse_end", 32'(bus.rsp_valid), 32'd0);

    // 2: write then immediate read-back
    single(2'b01, 4'd3, 8'hA5, 8'hA5, "wr3");
    single(2'b00, 4'd3, 8'h00, 8'hA5, "rd3");
    single(2'b00, 4'd4, 8'h00, 8'h00, "rd4");
    @(negedge clk);
    chk("rd4_hold_data", 32'(bus.rsp_data),  32'hA5 & 32'h00);
    chk("idle_valid",    32'(bus.rsp_valid), 32'd0);

    // 3: saturate high, then subtract without clamping
    single(2'b01, 4'd7, 8'hFC, 8'hFC, "wr7");
    update(4'd7, 5'd7,     8'hFF, 1'b1, "upd7_pos");
    update(4'd7, 5'b10000, 8'hEF, 1'b0, "upd7_neg");
    update(4'd7, 5'd0,     8'hEF, 1'b0, "upd7_zero");
    single(2'b00, 4'd7, 8'h00, 8'hEF, "rd7");

    // 4: saturate low
    single(2'b01, 4'd0, 8'h03, 8'h03, "wr0");
    update(4'd0, 5'b10000, 8'h00, 1'b1, "upd0_neg");
    single(2'b00, 4'd0, 8'h00, 8'h00, "rd0_after");

    // 5: fill, then clear with a READ held pending throughout
    for (int i = 0; i < 16; i++) begin
      drive(2'b01, 4'(i), 8'h11, 5'd0);
      @(negedge clk);
    end
    idle_bus();
    single(2'b00, 4'd9, 8'h00, 8'h11, "fill_rd9");
    drive(2'b11, 4'd0, 8'h00, 5'd0);
    @(negedge clk);
    drive(2'b00, 4'd5, 8'h00, 5'd0);
    busy_cnt = 0;
    rsp_seen = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      busy_cnt++;
      if (bus.rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("clr_rsp_in_busy", 32'(rsp_seen), 32'd0);
    chk("clr_rsp_valid",   32'(bus.rsp_valid), 32'd1);
    chk("clr_rsp_data",    32'(bus.rsp_data),  32'd0);
    chk("clr_rsp_sat",     32'(bus.rsp_sat),   32'd0);
    chk("clr_ready",       32'(bus.req_ready), 32'd1);
    @(negedge clk);
    idle_bus();
    chk("held_rd5_valid", 32'(bus.rsp_valid), 32'd1);
    chk("held_rd5_data",  32'(bus.rsp_data),  32'd0);
    @(negedge clk);
    chk("held_rd5_once",  32'(bus.rsp_valid), 32'd0);
    single(2'b00, 4'd15, 8'h00, 8'h00, "clr_rd15");
    single(2'b00, 4'd0,  8'h00, 8'h00, "clr_rd0");

    // 6: reset during UPD and during CLR
    single(2'b01, 4'd2, 8'h55, 8'h55, "wr2");
    drive(2'b10, 4'd2, 8'h00, 5'd1);
    @(negedge clk);
    idle_bus();
    chk("upd_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("upd_abort_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    chk("upd_abort_no_rsp", 32'(rsp_seen), 32'd0);
    single(2'b00, 4'd2, 8'h00, 8'h00, "upd_abort_rd2");

    single(2'b01, 4'd12, 8'h77, 8'h77, "wr12");
    drive(2'b11, 4'd0, 8'h00, 5'd0);
    @(negedge clk);
    idle_bus();
    repeat (7) @(negedge clk);
    chk("clr_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    chk("clr_abort_no_rsp", 32'(rsp_seen), 32'd0);
    chk("clr_abort_ready",  32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 4'(i), 8'h00, 5'd0);
      @(negedge clk);
      chk($sformatf("post_rst_data_%0d", i),  32'(bus.rsp_data),  32'd0);
      chk($sformatf("post_rst_ready_%0d", i), 32'(bus.req_ready), 32'd1);
    end
    idle_bus();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
